// File: rtl/histogram_cdf_reader.sv
// Histogram reader: sweeps 256 bins, accumulates a saturating CDF and writes a
// histogram-equalisation gray LUT. Optional macro HISTO_AUTOCLEAR_EN adds a bin-clear sweep.
module histogram_cdf_reader #(
    parameter int unsigned RD_LAT      = 2,
    parameter int unsigned SCALE_MUL   = 11141,
    parameter int unsigned SCALE_SHIFT = 24
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iStart,
    output logic        oBusy,
    output logic        oDone,
    output logic [7:0]  oHistoAddr,
    input  logic [19:0] iHistoVal,
    output logic        oHistoClear,
    output logic        oLutWe,
    output logic [7:0]  oLutAddr,
    output logic [7:0]  oLutData,
    output logic [19:0] oTotal,
    output logic        oOvf
);

    localparam int unsigned AW = 8;
    localparam int unsigned CW = 20;
    localparam int unsigned PW = 36;
    localparam logic [AW-1:0] LAST_BIN = '1;
    localparam logic [CW-1:0] CDF_MAX  = '1;
    localparam logic [PW-1:0] ROUND    = PW'(1) << (SCALE_SHIFT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SWEEP,
        S_DRAIN,
`ifdef HISTO_AUTOCLEAR_EN
        S_CLEAR,
`endif
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                we_q, we_d;
    logic [AW-1:0]       laddr_q, laddr_d;
    logic [AW-1:0]       ldata_q, ldata_d;
    logic [CW-1:0]       total_q, total_d;
    logic                ovf_q, ovf_d;
    logic [CW-1:0]       cdf_q, cdf_d;
    logic [AW-1:0]       cap_idx_q, cap_idx_d;
    logic [RD_LAT-1:0]   vld_q, vld_d;
    logic                hclr_q, hclr_d;

    logic                cap;
    logic [CW:0]         sum;
    logic [PW-1:0]       prod;
    logic [PW-1:0]       scaled;

    // Registered state, synchronous reset
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            we_q      <= 1'b0;
            laddr_q   <= '0;
            ldata_q   <= '0;
            total_q   <= '0;
            ovf_q     <= 1'b0;
            cdf_q     <= '0;
            cap_idx_q <= '0;
            vld_q     <= '0;
            hclr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            we_q      <= we_d;
            laddr_q   <= laddr_d;
            ldata_q   <= ldata_d;
            total_q   <= total_d;
            ovf_q     <= ovf_d;
            cdf_q     <= cdf_d;
            cap_idx_q <= cap_idx_d;
            vld_q     <= vld_d;
            hclr_q    <= hclr_d;
        end
    end

    // Next-state, CDF accumulation and LUT scaling
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        we_d      = 1'b0;
        laddr_d   = laddr_q;
        ldata_d   = ldata_q;
        total_d   = total_q;
        ovf_d     = ovf_q;
        cdf_d     = cdf_q;
        cap_idx_d = cap_idx_q;
        sum       = '0;
        prod      = '0;
        scaled    = '0;
        // Read-valid pipeline: bit RD_LAT-1 marks the cycle a swept bin's count arrives
        vld_d     = RD_LAT'({vld_q, state_q == S_SWEEP});
        cap       = vld_q[RD_LAT-1];

        case (state_q)
            S_IDLE: begin
                if (iStart) begin
                    state_d   = S_SWEEP;
                    addr_d    = '0;
                    cdf_d     = '0;
                    ovf_d     = 1'b0;
                    total_d   = '0;
                    cap_idx_d = '0;
                end
            end
            S_SWEEP: begin
                addr_d = addr_q + AW'(1);
                if (addr_q == LAST_BIN) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (we_q && (laddr_q == LAST_BIN)) begin
                    total_d = cdf_q;
                    addr_d  = '0;
`ifdef HISTO_AUTOCLEAR_EN
                    state_d = S_CLEAR;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef HISTO_AUTOCLEAR_EN
            S_CLEAR: begin
                addr_d = addr_q + AW'(1);
                if (addr_q == LAST_BIN) begin
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                addr_d  = '0;
            end
        endcase

        if (cap) begin
            sum = {1'b0, cdf_q} + {1'b0, iHistoVal};
            if (sum[CW]) begin
                cdf_d = CDF_MAX;
                ovf_d = 1'b1;
            end else begin
                cdf_d = sum[CW-1:0];
            end
            // Constant-reciprocal scaling with round-to-nearest, clamped to 8 bits
            prod      = PW'(cdf_d) * PW'(SCALE_MUL) + ROUND;
            scaled    = prod >> SCALE_SHIFT;
            ldata_d   = (|scaled[PW-1:AW]) ? '1 : scaled[AW-1:0];
            we_d      = 1'b1;
            laddr_d   = cap_idx_q;
            cap_idx_d = cap_idx_q + AW'(1);
        end

        done_d = (state_d == S_DONE);
`ifdef HISTO_AUTOCLEAR_EN
        hclr_d = (state_d == S_CLEAR);
        busy_d = (state_d == S_SWEEP) || (state_d == S_DRAIN) || (state_d == S_CLEAR);
`else
        hclr_d = 1'b0;
        busy_d = (state_d == S_SWEEP) || (state_d == S_DRAIN);
`endif
    end

    assign oBusy       = busy_q;
    assign oDone       = done_q;
    assign oHistoAddr  = addr_q;
    assign oHistoClear = hclr_q;
    assign oLutWe      = we_q;
    assign oLutAddr    = laddr_q;
    assign oLutData    = ldata_q;
    assign oTotal      = total_q;
    assign oOvf        = ovf_q;

endmodule

// File: tb/tb_histogram_cdf_reader.sv
// Self-checking bench for histogram_cdf_reader with a 2-cycle-latency histogram model.
module tb_histogram_cdf_reader;

    localparam int RD_LAT = 2;
`ifdef HISTO_AUTOCLEAR_EN
    localparam int CLR_CYC = 256;
`else
    localparam int CLR_CYC = 0;
`endif
    // oDone cycle counted from t0 (first cycle after the accepting edge)
    localparam int DONE_CYC = 256 + RD_LAT + 1 + CLR_CYC;
    localparam int CLR_BEG  = 256 + RD_LAT + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic [7:0]  haddr;
    logic [19:0] hval;
    logic        hclr;
    logic        we;
    logic [7:0]  laddr;
    logic [7:0]  ldata;
    logic [19:0] total;
    logic        ovf;

    logic [19:0] hist [256];
    logic [7:0]  a1, a2;
    logic        load_req;
    int          load_pat;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          pat;
        int          mid_start;
        logic [19:0] e_total;
        logic        e_ovf;
        logic [7:0]  e_lut0;
        logic [7:0]  e_lut255;
        int          e_ovf_first;
    } vec_t;

    vec_t vecs [5];

    always #5 clk = ~clk;

    histogram_cdf_reader #(
        .RD_LAT(RD_LAT), .SCALE_MUL(11141), .SCALE_SHIFT(24)
    ) dut (
        .iClk(clk), .iRst(rst), .iStart(start), .oBusy(busy), .oDone(done),
        .oHistoAddr(haddr), .iHistoVal(hval), .oHistoClear(hclr), .oLutWe(we),
        .oLutAddr(laddr), .oLutData(ldata), .oTotal(total), .oOvf(ovf)
    );

    function automatic logic [19:0] pat_val(input int pat, input int i);
        case (pat)
            1:       return (i == 0) ? 20'd384000 : 20'd0;
            2:       return 20'd1500;
            3:       return (i < 5) ? 20'd300000 : 20'd0;
            default: return 20'd0;
        endcase
    endfunction

    // Histogram RAM model: two-cycle read latency, clear on oHistoClear
    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 256; i++) hist[i] <= pat_val(load_pat, i);
        end else if (hclr) begin
            hist[haddr] <= 20'd0;
        end
        a1 <= haddr;
        a2 <= a1;
    end
    assign hval = hist[a2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_build(input vec_t v);
        logic [7:0] exp_lut [256];
        logic       exp_ov  [256];
        logic [7:0] cap     [256];
        longint     cdf = 0;
        longint     sc;
        logic       ov = 1'b0;
        int         wr = 0;
        int         done_cnt = 0;
        int         done_at = -1;
        int         first_ov = 256;
        int         exp_addr;
        logic       in_clr;
        for (int k = 0; k < 256; k++) begin
            cdf = cdf + longint'(pat_val(v.pat, k));
            if (cdf > 1048575) begin
                cdf = 1048575;
                ov  = 1'b1;
            end
            sc = (cdf * 11141 + 64'd8388608) >> 24;
            exp_lut[k] = (sc > 255) ? 8'd255 : 8'(sc);
            exp_ov[k]  = ov;
            cap[k]     = 8'd0;
        end
        @(negedge clk);
        if (v.pat >= 0) begin
            load_pat = v.pat;
            load_req = 1'b1;
            @(negedge clk);
            load_req = 1'b0;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < DONE_CYC + 20; cyc++) begin
            in_clr   = (cyc >= CLR_BEG) && (cyc < CLR_BEG + CLR_CYC);
            exp_addr = (cyc < 256) ? cyc : (in_clr ? cyc - CLR_BEG : 0);
            chk("histo_addr", 64'(haddr), 64'(exp_addr));
            chk("busy", 64'(busy), 64'(cyc < DONE_CYC));
            chk("histo_clear", 64'(hclr), 64'(in_clr));
            if (we) begin
                if (wr < 256) begin
                    chk("lut_addr", 64'(laddr), 64'(wr));
                    chk("lut_data", 64'(ldata), 64'(exp_lut[wr]));
                    chk("write_cycle", 64'(cyc), 64'(wr + RD_LAT + 1));
                    chk("ovf_during", 64'(ovf), 64'(exp_ov[wr]));
                    cap[wr] = ldata;
                    if (wr > 0) chk("monotonic", 64'(ldata >= cap[wr-1]), 64'd1);
                    if (ovf && first_ov == 256) first_ov = wr;
                end
                wr++;
            end
            if (done) begin
                done_cnt++;
                done_at = cyc;
            end
            start = (cyc == v.mid_start);
            @(negedge clk);
        end
        start = 1'b0;
        chk("write_count", 64'(wr), 64'd256);
        chk("done_count", 64'(done_cnt), 64'd1);
        chk("done_cycle", 64'(done_at), 64'(DONE_CYC));
        chk("total", 64'(total), 64'(v.e_total));
        chk("ovf_final", 64'(ovf), 64'(v.e_ovf));
        chk("ovf_first_bin", 64'(first_ov), 64'(v.e_ovf_first));
        chk("lut0", 64'(cap[0]), 64'(v.e_lut0));
        chk("lut255", 64'(cap[255]), 64'(v.e_lut255));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_addr"}, 64'(haddr), 64'd0);
        chk({tag, "_clear"}, 64'(hclr), 64'd0);
        chk({tag, "_we"}, 64'(we), 64'd0);
        chk({tag, "_laddr"}, 64'(laddr), 64'd0);
        chk({tag, "_ldata"}, 64'(ldata), 64'd0);
        chk({tag, "_total"}, 64'(total), 64'd0);
        chk({tag, "_ovf"}, 64'(ovf), 64'd0);
    endtask

    initial begin
        int   found;
        int   n_we;
        int   n_done;
        vec_t reread;

        // pat, mid_start, total, ovf, LUT[0], LUT[255], first ovf bin (256 = never)
        vecs[0] = '{0, -1, 20'd0,       1'b0, 8'd0,   8'd0,   256};
        vecs[1] = '{1, -1, 20'd384000,  1'b0, 8'd255, 8'd255, 256};
        vecs[2] = '{2, -1, 20'd384000,  1'b0, 8'd1,   8'd255, 256};
        vecs[3] = '{3, -1, 20'd1048575, 1'b1, 8'd199, 8'd255, 3};
        vecs[4] = '{1, 100, 20'd384000, 1'b0, 8'd255, 8'd255, 256};

        rst      = 1'b1;
        start    = 1'b0;
        load_req = 1'b0;
        load_pat = 0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_build(vecs[i]);

        // Reset in the middle of the sweep
        @(negedge clk);
        load_pat = 2;
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int c = 0; c < 300 && found == 0; c++) begin
            if (haddr == 8'd50) found = 1;
            else @(negedge clk);
        end
        chk("reached_bin50", 64'(found), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_all_zero("midrst");
        n_we   = 0;
        n_done = 0;
        for (int c = 0; c < 400; c++) begin
            if (we) n_we++;
            if (done) n_done++;
            @(negedge clk);
        end
        chk("post_rst_we", 64'(n_we), 64'd0);
        chk("post_rst_done", 64'(n_done), 64'd0);
        run_build(vecs[2]);

`ifdef HISTO_AUTOCLEAR_EN
        // Histogram was cleared by the previous build: re-read without reloading
        reread = '{-1, -1, 20'd0, 1'b0, 8'd0, 8'd0, 256};
        run_build(reread);
`else
        reread = vecs[0];
        run_build(reread);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
